// File: rtl/mlp_pkg.sv
// Shared MLP datapath types and helpers: handshake stage states, int8 limits
// and a width-generic saturating clamp used by both multiplier and accumulator.
package mlp_pkg;

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_t;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } clamp_t;

    // Clamps a sign-extended value into the signed range of an out_w-bit word.
    function automatic clamp_t sat_clamp_fn(input logic signed [63:0] val, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        clamp_t             res;
        hi        = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo        = -hi - 64'sd1;
        res.sat   = 1'b1;
        res.value = val;
        if (val > hi) begin
            res.value = hi;
        end else if (val < lo) begin
            res.value = lo;
        end else begin
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits,
// flagging whenever the input did not fit.
module sat_clamp
    import mlp_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] val_o,
    output logic                    sat_o
);

    clamp_t res;

    always_comb begin
        res   = sat_clamp_fn(64'(val_i), OUT_W);
        val_o = OUT_W'(res.value);
        sat_o = res.sat;
    end

endmodule

// File: rtl/int8_accum_stage.sv
// Saturating dot-product accumulator: sums one vector of int8 products,
// requantises to int8 with optional ReLU and hands the result downstream.
module int8_accum_stage
    import mlp_pkg::*;
#(
    parameter int ACC_W   = 16,
    parameter int MAX_LEN = 64,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [7:0]                in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [7:0]                out_data,
    output logic                             out_sat,
    output logic [$clog2(MAX_LEN+1)-1:0]     out_len,
    output logic                             err_len
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         count_q, count_d;
    logic                     sat_q, sat_d;
    logic signed [7:0]        out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic [LEN_W-1:0]         out_len_q, out_len_d;
    logic                     err_len_q, err_len_d;

    logic signed [ACC_W:0]    nsum;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     acc_sat;
    logic signed [7:0]        q8;
    logic                     q8_sat;
    logic [LEN_W-1:0]         count_inc;
    logic                     beat;
    logic                     hit_max;
    logic                     relu_zero;

    assign nsum      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(in_data);
    assign count_inc = count_q + LEN_W'(1);
    assign hit_max   = (count_inc == LEN_W'(MAX_LEN));
    assign beat      = in_valid && in_ready;

    sat_clamp #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_acc_clamp (
        .val_i (nsum),
        .val_o (acc_next),
        .sat_o (acc_sat)
    );

    sat_clamp #(.IN_W(ACC_W), .OUT_W(8)) u_out_clamp (
        .val_i (acc_next),
        .val_o (q8),
        .sat_o (q8_sat)
    );

    // A negative sum that ReLU maps to 0 is exact, so its int8 clamp is not reported.
    assign relu_zero = RELU_EN && acc_next[ACC_W-1];

    // Handshake outputs come straight from the state register, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_len   = out_len_q;
    assign err_len   = err_len_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        sat_d      = sat_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_len_d  = out_len_q;
        err_len_d  = err_len_q;
        case (state_q)
            S_ACC: begin
                if (beat) begin
                    acc_d   = acc_next;
                    count_d = count_inc;
                    sat_d   = sat_q | acc_sat;
                    if (in_last || hit_max) begin
                        out_data_d = relu_zero ? 8'sd0 : q8;
                        out_sat_d  = sat_q | acc_sat | (q8_sat & ~relu_zero);
                        out_len_d  = count_inc;
                        err_len_d  = err_len_q | ~in_last;
                        acc_d      = '0;
                        count_d    = '0;
                        sat_d      = 1'b0;
                        state_d    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over any update.
        if (rst) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_len_q  <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_len_q  <= out_len_d;
            err_len_q  <= err_len_d;
        end
    end

endmodule

// File: tb/tb_int8_accum_stage.sv
// Scoreboard bench: two stage instances (16-bit/64-beat/ReLU and 9-bit/4-beat/no ReLU)
// driven with directed and random vectors, checked against an integer reference model.
module tb_int8_accum_stage;

    localparam int W0  = 16;
    localparam int L0  = 64;
    localparam int W1  = 9;
    localparam int L1  = 4;
    localparam int LW0 = $clog2(L0 + 1);
    localparam int LW1 = $clog2(L1 + 1);

    logic clk = 1'b0;
    logic rst;
    logic in_valid  [2];
    logic in_ready  [2];
    logic in_last   [2];
    logic out_valid [2];
    logic out_ready [2];
    logic out_sat   [2];
    logic err_len   [2];
    logic signed [7:0] in_data  [2];
    logic signed [7:0] out_data [2];
    logic [LW0-1:0] out_len_a;
    logic [LW1-1:0] out_len_b;

    always #5 clk = ~clk;

    int8_accum_stage #(.ACC_W(W0), .MAX_LEN(L0), .RELU_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_sat(out_sat[0]), .out_len(out_len_a), .err_len(err_len[0])
    );

    int8_accum_stage #(.ACC_W(W1), .MAX_LEN(L1), .RELU_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_sat(out_sat[1]), .out_len(out_len_b), .err_len(err_len[1])
    );

    typedef struct {
        int data;
        bit sat;
        int len;
        bit err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   acc_m [2];
    int   cnt_m [2];
    bit   sat_m [2];
    bit   err_m [2];
    bit   rdy_rand [2];
    bit   rdy_hold [2];

    function automatic int lane_acc_w(int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic int lane_max_len(int k);
        return (k == 0) ? L0 : L1;
    endfunction

    function automatic bit lane_relu(int k);
        return (k == 0);
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0;
            cnt_m[k] = 0;
            sat_m[k] = 1'b0;
            err_m[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Reference: integer running sum clamped to the accumulator range, then ideal
    // result (ReLU applied) clamped to int8; any clamping on the way is saturation.
    function automatic void model_accept(int k, int d, bit last);
        int   hi;
        int   lo;
        int   s;
        int   ideal;
        exp_t e;
        hi = (1 << (lane_acc_w(k) - 1)) - 1;
        lo = -hi - 1;
        s  = acc_m[k] + d;
        if (s > hi) begin
            s = hi;
            sat_m[k] = 1'b1;
        end else if (s < lo) begin
            s = lo;
            sat_m[k] = 1'b1;
        end
        acc_m[k] = s;
        cnt_m[k]++;
        if (last || cnt_m[k] == lane_max_len(k)) begin
            if (!last) err_m[k] = 1'b1;
            ideal  = (lane_relu(k) && s < 0) ? 0 : s;
            e.sat  = sat_m[k] || ideal > 127 || ideal < -128;
            e.data = (ideal > 127) ? 127 : (ideal < -128) ? -128 : ideal;
            e.len  = cnt_m[k];
            e.err  = err_m[k];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            acc_m[k] = 0;
            cnt_m[k] = 0;
            sat_m[k] = 1'b0;
        end
    endfunction

    // Called on a falling edge; presents one beat and holds it until accepted.
    task automatic send(input int k, input int d, input bit last);
        int waited;
        waited      = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = 8'(d);
        in_last[k]  = last;
        while (in_ready[k] !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready[k] !== 1'b1) check($sformatf("in_ready_timeout[%0d]", k), 0, 1);
        else model_accept(k, d, last);
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic drain(input int k);
        int waited;
        waited = 0;
        while ((qsize(k) != 0 || out_valid[k] === 1'b1) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("drain_pending[%0d]", k), qsize(k), 0);
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            out_ready[k] = rdy_rand[k] ? ($urandom_range(0, 3) != 0) : rdy_hold[k];
        end
    end

    // Monitor: compares every presented result against the queue head, and pops on handshake.
    always @(negedge clk) begin
        exp_t e;
        int   len;
        if (rst === 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                if (out_valid[k] === 1'b1) begin
                    if (qsize(k) == 0) begin
                        check($sformatf("unexpected_out[%0d]", k), qsize(k), 1);
                    end else begin
                        e   = (k == 0) ? q0[0] : q1[0];
                        len = (k == 0) ? int'(out_len_a) : int'(out_len_b);
                        check($sformatf("out_data[%0d]", k), int'(out_data[k]), e.data);
                        check($sformatf("out_sat[%0d]", k), int'(out_sat[k]), int'(e.sat));
                        check($sformatf("out_len[%0d]", k), len, e.len);
                        check($sformatf("err_len[%0d]", k), int'(err_len[k]), int'(e.err));
                        if (out_ready[k] === 1'b1) begin
                            if (k == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            in_data[k]  = '0;
            in_last[k]  = 1'b0;
            rdy_rand[k] = 1'b0;
            rdy_hold[k] = 1'b1;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_in_ready[%0d]", k), int'(in_ready[k]), 1);
            check($sformatf("rst_out_valid[%0d]", k), int'(out_valid[k]), 0);
            check($sformatf("rst_out_data[%0d]", k), int'(out_data[k]), 0);
            check($sformatf("rst_out_sat[%0d]", k), int'(out_sat[k]), 0);
            check($sformatf("rst_err_len[%0d]", k), int'(err_len[k]), 0);
        end
        check("rst_out_len[0]", int'(out_len_a), 0);
        check("rst_out_len[1]", int'(out_len_b), 0);

        send(0, 10, 1'b0);
        send(0, 20, 1'b0);
        send(0, -5, 1'b1);
        check("latency_out_valid", int'(out_valid[0]), 1);
        drain(0);
        for (int i = 0; i < 4; i++) send(0, 127, i == 3);
        drain(0);
        send(0, -100, 1'b0);
        send(0, -50, 1'b1);
        drain(0);

        send(1, -100, 1'b0);
        send(1, -50, 1'b1);
        drain(1);
        for (int i = 0; i < 3; i++) send(1, 127, i == 2);
        drain(1);
        for (int i = 0; i < 5; i++) send(1, 1, 1'b0);
        send(1, 1, 1'b1);
        drain(1);
        check("err_len_sticky[1]", int'(err_len[1]), 1);

        rdy_hold[0] = 1'b0;
        send(0, 7, 1'b0);
        send(0, 8, 1'b1);
        repeat (5) begin
            check("bp_in_ready", int'(in_ready[0]), 0);
            check("bp_out_valid", int'(out_valid[0]), 1);
            @(negedge clk);
        end
        rdy_hold[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", int'(in_ready[0]), 1);
        check("bp_release_out_valid", int'(out_valid[0]), 0);

        send(0, 50, 1'b0);
        send(0, 50, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_in_ready", int'(in_ready[0]), 1);
        check("midrst_out_valid", int'(out_valid[0]), 0);
        check("midrst_err_len[1]", int'(err_len[1]), 0);
        send(0, 1, 1'b1);
        drain(0);

        rdy_rand[0] = 1'b1;
        rdy_rand[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            repeat (40) begin
                len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 70)) : int'($urandom_range(1, 8));
                for (int i = 0; i < len; i++) begin
                    send(k, int'($urandom_range(0, 255)) - 128, i == len - 1);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
            end
            drain(k);
            check($sformatf("final_err_len[%0d]", k), int'(err_len[k]), int'(err_m[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
